rc_inverse_filter: RTL
======================

// Module: rc_inverse_filter
// PURPOSE
//  Inverse (de-emphasis) of the first-order RC low-pass y[n]=a*x[n]+(1-a)*y[n-1]: recovers
//  x[n]=(y[n]-(1-a)*y[n-1])/a from a filtered Q(W-W_FRAC).W_FRAC stream. Sits downstream of the
//  low-pass on the same valid/ready stream. 2-stage pipeline with full backpressure, 1 sample/clk.
// PARAMETERS
//  W        16  total sample width, signed two's complement
//  W_FRAC    8  fractional bits (Q8.8 at defaults)
//  ALPHA    32  filter coefficient a in Q.W_FRAC (32 = 0.125); legal range 1..(1<<W_FRAC)
//  localparam ONE=1<<W_FRAC; INV_ALPHA=(ONE*ONE)/ALPHA (1/a in Q.W_FRAC, 2048 = 8.0 at defaults)
// PORTS
//  clk      in   1   clock, all state on rising edge
//  reset    in   1   asynchronous, active-high
//  clear    in   1   sync: zero history register y[n-1]
//  y_data   in   W   filtered sample, signed Q.W_FRAC
//  y_valid  in   1   y_data valid
//  y_ready  out  1   block accepts y_data this cycle
//  x_data   out  W   recovered sample, signed Q.W_FRAC, registered
//  x_valid  out  1   x_data valid
//  x_ready  in   1   downstream accepts x_data
//  x_sat    out  1   x_data was saturated; qualified by x_valid
// BEHAVIOUR
//  Reset (async assert): s1_valid=s2_valid=0, x_valid=0, x_data=0, x_sat=0, prev=0. Release sync.
//  Accept: in_fire=y_valid&&y_ready; out_fire=x_valid&&x_ready.
//  Stage 1 (on in_fire): fb=((ONE-ALPHA)*prev)[W+W_FRAC-1:W_FRAC] (2W signed product, truncated);
//   s1_diff <= signed(y_data)-fb, W+1 bits, no overflow possible; prev <= y_data.
//  Stage 2 (register = x_data): p=s1_diff*INV_ALPHA (2W+2 signed), q=p>>>W_FRAC (arithmetic);
//   q>2^(W-1)-1 -> x_data=0x7FF..F, x_sat=1; q<-2^(W-1) -> x_data=0x800..0, x_sat=1;
//   else x_data=q[W-1:0], x_sat=0. All operands cast signed; truncation floors toward -inf.
//  Flow: s2_en = !x_valid || x_ready; s1_en = !s1_valid || s2_en; y_ready = s1_en (combinational
//   from x_ready, no comb path y_valid->y_ready). s2 loads s1 when s2_en; x_valid <= s1_valid then.
//  Latency: in_fire at cycle N -> x_valid at N+2 when x_ready held 1. Throughput 1/clk.
//  Backpressure: x_ready=0 holds x_data/x_valid/x_sat stable; pipeline absorbs 2 samples, then
//   y_ready=0. No sample dropped, duplicated or reordered.
//  Empty: x_valid=0, x_data holds last value (don't-care).
//  clear: prev <= 0 at next edge; if in_fire same cycle, that sample uses fb=0 and prev <= y_data
//   (clear applies to history before the sample, sample wins for the update). In-flight samples unaffected.
//  Reset mid-operation: in-flight samples discarded, outputs to reset values immediately.
//  prev updates only on in_fire; idle cycles do not advance history.
// TESTING
//  T1 step: reset, x_ready=1, feed y=0x0020,0x003C -> x_data=0x0100,0x0100 at +2 clk each, x_sat=0.
//  T2 round trip: rc_low_pass(ALPHA=32) -> this block, 200 random Q8.8 in [-4,4) -> |err|<=3 LSB.
//  T3 saturation: prev=0, y=0x7FFF -> x_data=0x7FFF,x_sat=1; then clear, y=0x8000 -> 0x8000,x_sat=1.
//  T4 backpressure: x_ready=0, offer 3 samples -> exactly 2 accepted, y_ready=0; x_ready=1 ->
//   3 outputs in order, back-to-back, none lost/repeated; random x_ready 50% for 500 samples vs model.
//  T5 clear: prev=0x0100, clear with y=0x0020 accepted -> x=0x0100 (fb=0); next y=0x0020 -> fb=0x1C, x=0x0020.
//  T6 reset mid-stream: assert reset between edges with 2 in flight -> x_valid=0 at once, no
//   stale output after release, first new y=0x0020 -> 0x0100.

Source files
------------

// File: rtl/rc_inverse_filter_if.sv
// rc_inverse_filter_if: valid/ready streams into and out of the RC inverse filter, plus the history clear
//   clear                    sync strobe: zero the y[n-1] history
//   y_data/y_valid/y_ready   filtered input stream, signed Q.W_FRAC
//   x_data/x_valid/x_ready   recovered output stream, signed Q.W_FRAC
//   x_sat                    x_data was saturated, qualified by x_valid
interface rc_inverse_filter_if #(parameter int W = 16);
  logic clear;
  logic [W-1:0] y_data;
  logic y_valid;
  logic y_ready;
  logic [W-1:0] x_data;
  logic x_valid;
  logic x_ready;
  logic x_sat;
  modport slave (input clear, y_data, y_valid, x_ready, output y_ready, x_data, x_valid, x_sat);
  modport master (output clear, y_data, y_valid, x_ready, input y_ready, x_data, x_valid, x_sat);
endinterface

// File: rtl/rc_inverse_filter.sv
// rc_inverse_filter: recovers x[n]=(y[n]-(1-a)*y[n-1])/a from an RC low-passed stream, 2-stage valid/ready pipeline
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    slave side of rc_inverse_filter_if (clear, y stream in, x stream out with x_sat)
module rc_inverse_filter #(
  parameter int W = 16,
  parameter int W_FRAC = 8,
  parameter int ALPHA = 32
) (
  input logic clk,
  input logic reset,
  rc_inverse_filter_if.slave bus
);
  localparam int ONE = 1 << W_FRAC;
  localparam int INV_ALPHA = (ONE * ONE) / ALPHA;
  localparam int WF = W + W_FRAC;
  localparam int WP = 2 * W + 2;
  localparam logic signed [WF-1:0] C_FB = WF'(ONE - ALPHA);
  localparam logic signed [WP-1:0] C_INV = WP'(INV_ALPHA);
  localparam logic signed [WP-1:0] C_MAX = WP'((1 << (W - 1)) - 1);
  localparam logic signed [WP-1:0] C_MIN = ~C_MAX;
  logic signed [W-1:0] r_prev, r_x_data, w_fb;
  logic signed [W:0] r_s1_diff, w_diff;
  logic signed [WP-1:0] w_p, w_q;
  logic r_s1_valid, r_x_valid, r_x_sat, w_s1_en, w_s2_en, w_in_fire, w_hi, w_lo;
  assign w_s2_en = !r_x_valid || bus.x_ready;
  assign w_s1_en = !r_s1_valid || w_s2_en;
  assign w_in_fire = bus.y_valid && w_s1_en;
  // |(1-a)*prev| < 2^(W+W_FRAC-1), so a W+W_FRAC product holds it exactly before the floor shift
  assign w_fb = bus.clear ? '0 : W'((C_FB * $signed({{W_FRAC{r_prev[W-1]}}, r_prev})) >>> W_FRAC);
  assign w_diff = $signed({bus.y_data[W-1], bus.y_data}) - $signed({w_fb[W-1], w_fb});
  assign w_p = C_INV * $signed({{(W + 1){r_s1_diff[W]}}, r_s1_diff});
  assign w_q = w_p >>> W_FRAC;
  assign w_hi = w_q > C_MAX;
  assign w_lo = w_q < C_MIN;
  assign bus.y_ready = w_s1_en;
  assign bus.x_data = r_x_data;
  assign bus.x_valid = r_x_valid;
  assign bus.x_sat = r_x_sat;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_prev <= '0;
      r_s1_diff <= '0;
      r_s1_valid <= 1'b0;
      r_x_data <= '0;
      r_x_valid <= 1'b0;
      r_x_sat <= 1'b0;
    end else begin
      // an accepted sample overrides clear for the history update
      if (w_in_fire) begin
        r_prev <= $signed(bus.y_data);
        r_s1_diff <= w_diff;
      end else if (bus.clear) begin
        r_prev <= '0;
      end
      if (w_s1_en) r_s1_valid <= bus.y_valid;
      if (w_s2_en) r_x_valid <= r_s1_valid;
      if (w_s2_en && r_s1_valid) begin
        r_x_data <= w_hi ? C_MAX[W-1:0] : w_lo ? C_MIN[W-1:0] : w_q[W-1:0];
        r_x_sat <= w_hi || w_lo;
      end
    end
endmodule
